// File: rtl/tri_fifo_reg.sv
// Triangle holding register: pops vertex/color pairs in lockstep from
// two FIFOs and presents three of them in parallel to the rasterizer.
module tri_fifo_reg #(
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vertex_empty,
  input  logic              color_empty,
  input  logic [DATA_W-1:0] vertex_in,
  input  logic [DATA_W-1:0] color_in,
  output logic              vertex_rd_en,
  output logic              color_rd_en,
  input  logic              dequeue,
  output logic              ready,
  output logic [DATA_W-1:0] vertex_out,
  output logic [DATA_W-1:0] vertex_out2,
  output logic [DATA_W-1:0] vertex_out3,
  output logic [DATA_W-1:0] color_out,
  output logic [DATA_W-1:0] color_out2,
  output logic [DATA_W-1:0] color_out3
);

  logic [1:0]        issued_q, issued_d;
  logic [1:0]        captured_q, captured_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd;
  logic [DATA_W-1:0] v0_q, v1_q, v2_q, v0_d, v1_d, v2_d;
  logic [DATA_W-1:0] c0_q, c1_q, c2_q, c0_d, c1_d, c2_d;

  assign ready = (captured_q == 2'd3);

  always_comb begin
    rd = !vertex_empty && !color_empty
      && (issued_q != 2'd3) && !rst;
  end

  assign vertex_rd_en = rd;
  assign color_rd_en  = rd;

  always_comb begin
    issued_d   = issued_q;
    captured_d = captured_q;
    rd_valid_d = rd;
    v0_d = v0_q; v1_d = v1_q; v2_d = v2_q;
    c0_d = c0_q; c1_d = c1_q; c2_d = c2_q;
    if (rd) issued_d = issued_q + 2'd1;
    if (rd_valid_q) begin
      captured_d = captured_q + 2'd1;
      unique case (captured_q)
        2'd0: begin v0_d = vertex_in; c0_d = color_in; end
        2'd1: begin v1_d = vertex_in; c1_d = color_in; end
        2'd2: begin v2_d = vertex_in; c2_d = color_in; end
        default: captured_d = captured_q;
      endcase
    end
    // issued==3 blocks rd, so a dequeue never races a new read
    if (ready && dequeue) begin
      issued_d   = 2'd0;
      captured_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q   <= 2'd0;
      captured_q <= 2'd0;
      rd_valid_q <= 1'b0;
      v0_q <= '0; v1_q <= '0; v2_q <= '0;
      c0_q <= '0; c1_q <= '0; c2_q <= '0;
    end else begin
      issued_q   <= issued_d;
      captured_q <= captured_d;
      rd_valid_q <= rd_valid_d;
      v0_q <= v0_d; v1_q <= v1_d; v2_q <= v2_d;
      c0_q <= c0_d; c1_q <= c1_d; c2_q <= c2_d;
    end
  end

  assign vertex_out  = v0_q;
  assign vertex_out2 = v1_q;
  assign vertex_out3 = v2_q;
  assign color_out   = c0_q;
  assign color_out2  = c1_q;
  assign color_out3  = c2_q;

endmodule

// File: tb/tb_tri_fifo_reg.sv
// Directed bench for tri_fifo_reg with FIFO models and a scoreboard.
module tb_tri_fifo_reg;

  localparam int W = 96;

  logic         clk = 1'b0;
  logic         rst;
  logic         vertex_empty, color_empty;
  logic [W-1:0] vertex_in, color_in;
  logic         vertex_rd_en, color_rd_en;
  logic         dequeue;
  logic         ready;
  logic [W-1:0] vertex_out, vertex_out2, vertex_out3;
  logic [W-1:0] color_out, color_out2, color_out3;

  tri_fifo_reg #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .vertex_empty(vertex_empty), .color_empty(color_empty),
    .vertex_in(vertex_in), .color_in(color_in),
    .vertex_rd_en(vertex_rd_en), .color_rd_en(color_rd_en),
    .dequeue(dequeue), .ready(ready),
    .vertex_out(vertex_out), .vertex_out2(vertex_out2),
    .vertex_out3(vertex_out3),
    .color_out(color_out), .color_out2(color_out2),
    .color_out3(color_out3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] vq[$], cq[$];
  logic [W-1:0] sbv[$], sbc[$];
  logic [W-1:0] lv[3], lc[3];
  logic         hold_c = 1'b0;
  logic         rd_s;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic upd_flags();
    vertex_empty = (vq.size() == 0);
    color_empty  = (cq.size() == 0) || hold_c;
  endtask

  task automatic push(input logic [W-1:0] v, input logic [W-1:0] c);
    vq.push_back(v); cq.push_back(c);
    sbv.push_back(v); sbc.push_back(c);
    upd_flags();
  endtask

  // one clock: sample strobes mid-cycle, model FIFO read at the edge
  task automatic tick();
    @(negedge clk);
    rd_s = vertex_rd_en;
    chk("rd_lockstep", {95'd0, color_rd_en}, {95'd0, rd_s});
    if (rst) chk("rd_in_rst", {95'd0, rd_s}, '0);
    @(posedge clk);
    #1;
    if (rd_s) begin
      vertex_in = vq.pop_front();
      color_in  = cq.pop_front();
    end
    upd_flags();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 12) begin tick(); n++; end
    chk("ready_timeout", {95'd0, ready}, {95'd0, 1'b1});
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_v1"}, vertex_out,  lv[0]);
    chk({tag, "_v2"}, vertex_out2, lv[1]);
    chk({tag, "_v3"}, vertex_out3, lv[2]);
    chk({tag, "_c1"}, color_out,   lc[0]);
    chk({tag, "_c2"}, color_out2,  lc[1]);
    chk({tag, "_c3"}, color_out3,  lc[2]);
  endtask

  task automatic chk_tri(input string tag);
    for (int i = 0; i < 3; i++) begin
      lv[i] = sbv.pop_front();
      lc[i] = sbc.pop_front();
    end
    chk_outs(tag);
  endtask

  task automatic deq();
    dequeue = 1'b1;
    tick();
    dequeue = 1'b0;
  endtask

  function automatic logic [W-1:0] rv(input int k);
    return {$urandom(), $urandom(), 32'(k)};
  endfunction

  initial begin
    rst = 1'b1; dequeue = 1'b0;
    vertex_in = '0; color_in = '0;
    push(96'h3F800000_3F800000_00000000, 96'h3F800000_00000000_00000000);
    push(96'h40000000_3F800000_00000000, 96'h3F800000_00000000_00000000);
    push(96'h3F800000_41200000_00000000, 96'h3F800000_00000000_00000000);
    #1;
    for (int i = 0; i < 3; i++) begin lv[i] = '0; lc[i] = '0; end
    // reset held two cycles with non-empty FIFOs
    tick();
    chk("rst_ready", {95'd0, ready}, '0);
    chk_outs("rst");
    tick();
    rst = 1'b0;

    // first triangle: 3 back-to-back reads, ready 4 cycles after first
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_rd", {95'd0, rd_s}, {95'd0, 1'b1});
    end
    chk("t2_notready", {95'd0, ready}, '0);
    tick();
    chk("t2_rd4", {95'd0, rd_s}, '0);
    chk("t2_ready", {95'd0, ready}, {95'd0, 1'b1});
    chk_tri("t2");

    // held while ready without dequeue, even with data waiting
    for (int k = 0; k < 3; k++) push(rv(10 + k), rv(20 + k));
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_no_rd", {95'd0, rd_s}, '0);
      chk("t4_ready", {95'd0, ready}, {95'd0, 1'b1});
    end
    chk_outs("t4_hold");
    deq();
    chk("t4_deq_ready", {95'd0, ready}, '0);
    chk_outs("t4_after_deq");
    tick();
    chk("t4_new_rd", {95'd0, rd_s}, {95'd1});
    wait_ready();
    chk_tri("t4_next");
    deq();

    // color FIFO starved: no lone vertex read
    hold_c = 1'b1;
    for (int k = 0; k < 3; k++) push(rv(30 + k), rv(40 + k));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_no_rd", {95'd0, rd_s}, '0);
      chk("t3_ready", {95'd0, ready}, '0);
    end
    chk_outs("t3_untouched");
    hold_c = 1'b0;
    upd_flags();
    tick();
    chk("t3_resume", {95'd0, rd_s}, {95'd1});
    wait_ready();
    chk_tri("t3");
    deq();

    // empty after two pops, then third pair arrives
    push(rv(50), rv(60));
    push(rv(51), rv(61));
    for (int i = 0; i < 6; i++) tick();
    chk("t5_ready", {95'd0, ready}, '0);
    chk("t5_v1", vertex_out,  sbv[0]);
    chk("t5_v2", vertex_out2, sbv[1]);
    chk("t5_c1", color_out,   sbc[0]);
    chk("t5_c2", color_out2,  sbc[1]);
    push(rv(52), rv(62));
    tick();
    chk("t5_rd3", {95'd0, rd_s}, {95'd1});
    chk("t5_notyet", {95'd0, ready}, '0);
    tick();
    chk("t5_ready2", {95'd0, ready}, {95'd1});
    chk_tri("t5");
    deq();

    // reset one cycle after a read: that pair is dropped
    for (int k = 0; k < 3; k++) push(rv(70 + k), rv(80 + k));
    tick();
    chk("t6_rd", {95'd0, rd_s}, {95'd1});
    void'(sbv.pop_front());
    void'(sbc.pop_front());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin lv[i] = '0; lc[i] = '0; end
    chk("t6_ready", {95'd0, ready}, '0);
    chk_outs("t6_rst");
    push(rv(73), rv(83));
    wait_ready();
    chk_tri("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tri_fifo_reg.md
Name: tri_fifo_reg

Overview:
- Peek/holding register between the vertex and color FIFOs (read side) and the rasterizer.
- Pops vertex/color pairs from the two FIFOs in lockstep and assembles three of them into one triangle.
- Presents all three vertices and colors in parallel with a `ready` flag.
- Frees the triangle when the rasterizer pulses `dequeue`.

Parameters:
- DATA_W, 96, width of one vertex or color word (three 32-bit IEEE floats: x, y, z or r, g, b).

Ports:
- clk  in  1  single clock, shared with the FIFO read side and the rasterizer.
- rst  in  1  synchronous reset, active-high.
- vertex_empty  in  1  vertex FIFO empty flag.
- color_empty  in  1  color FIFO empty flag.
- vertex_in  in  DATA_W  vertex FIFO read data; valid one cycle after vertex_rd_en.
- color_in  in  DATA_W  color FIFO read data; valid one cycle after color_rd_en.
- vertex_rd_en  out  1  vertex FIFO read strobe.
- color_rd_en  out  1  color FIFO read strobe.
- dequeue  in  1  rasterizer has consumed the current triangle.
- ready  out  1  all three vertex/color slots are valid.
- vertex_out  out  DATA_W  vertex 1 (first popped).
- vertex_out2  out  DATA_W  vertex 2.
- vertex_out3  out  DATA_W  vertex 3.
- color_out  out  DATA_W  color 1.
- color_out2  out  DATA_W  color 2.
- color_out3  out  DATA_W  color 3.

Behaviour:
- Internal state:
  - issued: 2-bit count (0..3) of reads issued for the current triangle.
  - captured: 2-bit count (0..3) of slots filled.
  - rd_valid: 1-bit flag, registered copy of the read strobe.
- Read strobe:
  - rd = !vertex_empty && !color_empty && issued<3 && !rst.
  - rd is combinational from registered state and the empty flags.
  - vertex_rd_en = color_rd_en = rd, always identical.
  - A FIFO is never read alone. If only one FIFO is non-empty, no read occurs.
- Issue: on a cycle with rd=1, issued increments and rd_valid<=1 next edge; otherwise rd_valid<=0.
- Capture (FIFO read latency is 1 cycle):
  - On a cycle with rd_valid=1, vertex_in/color_in are written into slot[captured], and captured increments.
  - Slot 0 drives vertex_out/color_out, slot 1 drives the *_out2 ports, slot 2 drives the *_out3 ports.
- Throughput: back-to-back reads are allowed. A full triangle is issued in 3 consecutive cycles when both FIFOs stay non-empty.
- ready = (captured==3), registered state only.
  - First ready cycle is 4 cycles after the first rd when the FIFOs are continuously non-empty.
- dequeue:
  - With ready=1: issued<=0, captured<=0 at the next edge, and ready falls the cycle after dequeue.
  - With ready=0: ignored.
  - No prefetch of the next triangle occurs while ready=1, because issued==3 blocks rd.
- Slot contents:
  - Retain their values after dequeue until overwritten; outputs are not cleared.
  - Never change while ready=1.
- Reset (synchronous, rst=1 at a rising edge):
  - issued, captured, rd_valid <= 0.
  - All six data outputs <= 0.
  - ready <= 0.
  - rd_en is forced 0 during any cycle rst is high.
- Reset mid-operation: a read issued in the cycle before reset is discarded, and its data is not captured. FIFO contents are not restored; this is the FIFO owner's responsibility.
- Simultaneous events:
  - rd and capture in the same cycle are normal pipelining.
  - dequeue while ready cannot coincide with rd (issued==3).
  - rst overrides everything.
- Empty mid-triangle: reads pause. Partially captured slots are held and the triangle completes when both FIFOs become non-empty again.
- No arithmetic on data; words are passed bit-exact.

Test Plan:
1. Reset: hold rst 2 cycles with both FIFOs non-empty.
   -> rd_en=0 throughout, ready=0, all outputs 0x0 after the first edge.
2. Preload FIFO pairs with vertices (1,1,0)=0x3F800000_3F800000_00000000, (2,1,0)=0x40000000_3F800000_00000000, (1,10,0)=0x3F800000_41200000_00000000 and colors 0x3F800000_00000000_00000000 ×3.
   -> rd_en high 3 consecutive cycles, ready=1 at the 4th cycle after the first rd, slots hold the values in push order.
3. Only the vertex FIFO non-empty (color_empty=1) for 10 cycles.
   -> rd_en stays 0 and captured stays 0. Deassert color_empty -> reads resume in lockstep.
4. ready=1 with dequeue held 0 for 20 cycles.
   -> no further rd_en, outputs stable. Pulse dequeue 1 cycle -> ready=0 the next cycle, outputs unchanged, new reads begin.
5. Make both FIFOs empty after 2 pops.
   -> captured=2, ready=0, slots 0/1 held. Push a third pair -> ready rises 2 cycles after its rd.
6. Assert rst one cycle after an rd.
   -> that data is not captured, ready=0, counters restart from 0, and the next triangle fills slots starting at vertex_out.
